arp_cache_table: RTL and testbench

- Parametrised ARP cache for the Ethernet RX/TX path. Learns sender IP/MAC pairs from received ARP frames after the FCS check passes.
- Serves single-cycle IP-to-MAC lookups to the IP TX path and ages out stale entries.
- Triggers the ARP reply generator when a request targets the local IP.
- Sits between the ARP RX parser/CRC checker and the TX frame builder.

---
 rtl/arp_cache_table.sv | 231 +++++++++++++++++++++++
 tb/tb_arp_cache_table.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_cache_table.sv
// ARP cache: learns sender IP/MAC pairs from FCS-checked ARP frames, serves
// single-cycle IP-to-MAC lookups, ages out stale entries and requests replies.
module arp_cache_table #(
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned TICK_CYCLES = 125000000,
  parameter int unsigned AGE_LIMIT   = 300,
  parameter logic [31:0] LOCAL_IP    = 32'hC0A8010A,
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        rx_arp_done,
  input  logic [15:0] rx_opcode,
  input  logic [47:0] rx_mac_s_addr,
  input  logic [31:0] rx_ip_s_addr,
  input  logic [31:0] rx_ip_t_addr,
  input  logic        crc_valid,
  input  logic        crc_error,
  output logic        arp_resp_start,
  input  logic        arp_resp_end,
  output logic [47:0] resp_mac_d_addr,
  output logic [31:0] resp_ip_d_addr,
  output logic [47:0] mac_s_addr,
  output logic [31:0] ip_s_addr,
  input  logic        lkp_req,
  input  logic [31:0] lkp_ip,
  output logic        lkp_ack,
  output logic        lkp_hit,
  output logic [47:0] lkp_mac
);

  localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned AW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FCS,
    S_UPDATE,
    S_ARP_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_latch;

  logic [15:0]   r_opcode;
  logic [47:0]   r_smac;
  logic [31:0]   r_sip;
  logic [31:0]   r_tip;

  logic          r_vld [ENTRIES];
  logic [31:0]   r_ip  [ENTRIES];
  logic [47:0]   r_mac [ENTRIES];
  logic [AW-1:0] r_age [ENTRIES];
  logic [IW-1:0] r_repl;
  logic [TW-1:0] r_tick;

  logic          w_tick;
  logic          w_upd_hit;
  logic [IW-1:0] w_upd_idx;
  logic          w_free_any;
  logic [IW-1:0] w_free_idx;
  logic          w_wr_en;
  logic [IW-1:0] w_wr_idx;
  logic          w_lkp_hit;
  logic [47:0]   w_lkp_mac;

  logic          r_resp_start;
  logic [47:0]   r_resp_mac;
  logic [31:0]   r_resp_ip;
  logic          r_lkp_ack;
  logic          r_lkp_hit;
  logic [47:0]   r_lkp_mac;

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state; FCS verdict outranks a relatch, crc_error outranks crc_valid
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_arp_done) begin
          w_latch     = 1'b1;
          w_state_nxt = S_WAIT_FCS;
        end
      end
      S_WAIT_FCS: begin
        if (crc_error)        w_state_nxt = S_IDLE;
        else if (crc_valid)   w_state_nxt = S_UPDATE;
        else if (rx_arp_done) w_latch     = 1'b1;
      end
      S_UPDATE: begin
        if (r_opcode == 16'd1 && r_tip == LOCAL_IP) w_state_nxt = S_ARP_RESP;
        else                                        w_state_nxt = S_IDLE;
      end
      S_ARP_RESP: begin
        if (arp_resp_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_opcode <= '0;
      r_smac   <= '0;
      r_sip    <= '0;
      r_tip    <= '0;
    end else if (w_latch) begin
      r_opcode <= rx_opcode;
      r_smac   <= rx_mac_s_addr;
      r_sip    <= rx_ip_s_addr;
      r_tip    <= rx_ip_t_addr;
    end
  end

  // Sender match and first free slot; downward scan makes lowest index win
  always_comb begin
    w_upd_hit  = 1'b0;
    w_upd_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_vld[i] && r_ip[i] == r_sip) begin
        w_upd_hit = 1'b1;
        w_upd_idx = IW'(i);
      end
      if (!r_vld[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  assign w_wr_en  = (r_state == S_UPDATE) && (r_sip != 32'd0) &&
                    (w_upd_hit || r_tip == LOCAL_IP);
  assign w_wr_idx = w_upd_hit ? w_upd_idx : (w_free_any ? w_free_idx : r_repl);
  assign w_tick   = (r_tick == TW'(TICK_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tick <= '0;
      r_repl <= '0;
    end else begin
      r_tick <= w_tick ? '0 : r_tick + TW'(1);
      if (w_wr_en && !w_upd_hit && !w_free_any) r_repl <= r_repl + IW'(1);
    end
  end

  // Entry storage; a write (refresh or insert) takes priority over aging
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_vld[i] <= 1'b0;
        r_ip[i]  <= '0;
        r_mac[i] <= '0;
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_wr_en && w_wr_idx == IW'(i)) begin
          r_vld[i] <= 1'b1;
          r_ip[i]  <= r_sip;
          r_mac[i] <= r_smac;
          r_age[i] <= '0;
        end else if (w_tick && r_vld[i]) begin
          if (r_age[i] == AW'(AGE_LIMIT - 1)) begin
            r_vld[i] <= 1'b0;
            r_age[i] <= '0;
          end else begin
            r_age[i] <= r_age[i] + AW'(1);
          end
        end
      end
    end
  end

  // Lookup compare against the current (pre-update) table
  always_comb begin
    w_lkp_hit = 1'b0;
    w_lkp_mac = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_vld[i] && r_ip[i] == lkp_ip) begin
        w_lkp_hit = 1'b1;
        w_lkp_mac = r_mac[i];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_lkp_ack <= 1'b0;
      r_lkp_hit <= 1'b0;
      r_lkp_mac <= '0;
    end else begin
      r_lkp_ack <= lkp_req;
      r_lkp_hit <= lkp_req && w_lkp_hit;
      r_lkp_mac <= (lkp_req && w_lkp_hit) ? w_lkp_mac : '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_resp_start <= 1'b0;
      r_resp_mac   <= '0;
      r_resp_ip    <= '0;
    end else begin
      r_resp_start <= (w_state_nxt == S_ARP_RESP);
      if (r_state == S_UPDATE && w_state_nxt == S_ARP_RESP) begin
        r_resp_mac <= r_smac;
        r_resp_ip  <= r_sip;
      end
    end
  end

  assign arp_resp_start  = r_resp_start;
  assign resp_mac_d_addr = r_resp_mac;
  assign resp_ip_d_addr  = r_resp_ip;
  assign mac_s_addr      = LOCAL_MAC;
  assign ip_s_addr       = LOCAL_IP;
  assign lkp_ack         = r_lkp_ack;
  assign lkp_hit         = r_lkp_hit;
  assign lkp_mac         = r_lkp_mac;

endmodule

// File: tb/tb_arp_cache_table.sv
// Directed bench for arp_cache_table: one long-tick instance for learning,
// replies and lookups, and one short-tick instance for aging.
module tb_arp_cache_table;

  localparam logic [31:0] LIP  = 32'hC0A8010A;
  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        rx_arp_done = 1'b0;
  logic [15:0] rx_opcode = '0;
  logic [47:0] rx_mac_s_addr = '0;
  logic [31:0] rx_ip_s_addr = '0;
  logic [31:0] rx_ip_t_addr = '0;
  logic        crc_valid = 1'b0;
  logic        crc_error = 1'b0;
  logic        arp_resp_end = 1'b0;
  logic        lkp_req = 1'b0;
  logic [31:0] lkp_ip = '0;

  logic        m_start, a_start;
  logic [47:0] m_resp_mac, a_resp_mac;
  logic [31:0] m_resp_ip, a_resp_ip;
  logic [47:0] m_mac_s, a_mac_s;
  logic [31:0] m_ip_s, a_ip_s;
  logic        m_ack, a_ack;
  logic        m_hit, a_hit;
  logic [47:0] m_lmac, a_lmac;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  always #5 aclk = ~aclk;

  arp_cache_table #(.ENTRIES(8), .TICK_CYCLES(1000), .AGE_LIMIT(300),
                    .LOCAL_IP(LIP), .LOCAL_MAC(LMAC)) dut (
    .aclk(aclk), .aresetn(aresetn), .rx_arp_done(rx_arp_done),
    .rx_opcode(rx_opcode), .rx_mac_s_addr(rx_mac_s_addr),
    .rx_ip_s_addr(rx_ip_s_addr), .rx_ip_t_addr(rx_ip_t_addr),
    .crc_valid(crc_valid), .crc_error(crc_error),
    .arp_resp_start(m_start), .arp_resp_end(arp_resp_end),
    .resp_mac_d_addr(m_resp_mac), .resp_ip_d_addr(m_resp_ip),
    .mac_s_addr(m_mac_s), .ip_s_addr(m_ip_s),
    .lkp_req(lkp_req), .lkp_ip(lkp_ip),
    .lkp_ack(m_ack), .lkp_hit(m_hit), .lkp_mac(m_lmac));

  arp_cache_table #(.ENTRIES(8), .TICK_CYCLES(10), .AGE_LIMIT(3),
                    .LOCAL_IP(LIP), .LOCAL_MAC(LMAC)) dut_age (
    .aclk(aclk), .aresetn(aresetn), .rx_arp_done(rx_arp_done),
    .rx_opcode(rx_opcode), .rx_mac_s_addr(rx_mac_s_addr),
    .rx_ip_s_addr(rx_ip_s_addr), .rx_ip_t_addr(rx_ip_t_addr),
    .crc_valid(crc_valid), .crc_error(crc_error),
    .arp_resp_start(a_start), .arp_resp_end(arp_resp_end),
    .resp_mac_d_addr(a_resp_mac), .resp_ip_d_addr(a_resp_ip),
    .mac_s_addr(a_mac_s), .ip_s_addr(a_ip_s),
    .lkp_req(lkp_req), .lkp_ip(lkp_ip),
    .lkp_ack(a_ack), .lkp_hit(a_hit), .lkp_mac(a_lmac));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    edge_n++;
    #1;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    edge_n  = 0;
  endtask

  task automatic frame(input logic [15:0] op, input logic [47:0] m,
                       input logic [31:0] sip, input logic [31:0] tip);
    rx_arp_done   = 1'b1;
    rx_opcode     = op;
    rx_mac_s_addr = m;
    rx_ip_s_addr  = sip;
    rx_ip_t_addr  = tip;
    step();
    rx_arp_done   = 1'b0;
  endtask

  task automatic crc(input logic ok, input logic bad);
    crc_valid = ok;
    crc_error = bad;
    step();
    crc_valid = 1'b0;
    crc_error = 1'b0;
  endtask

  task automatic lookup(input bit sel, input logic [31:0] ip, input logic hit,
                        input logic [47:0] mac, input string tag);
    lkp_req = 1'b1;
    lkp_ip  = ip;
    step();
    lkp_req = 1'b0;
    chk({tag, "_ack"}, 64'(sel ? a_ack : m_ack), 64'd1);
    chk({tag, "_hit"}, 64'(sel ? a_hit : m_hit), 64'(hit));
    chk({tag, "_mac"}, 64'(sel ? a_lmac : m_lmac), 64'(mac));
  endtask

  initial begin
    do_reset();
    chk("rst_start", 64'(m_start), 64'd0);
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_hit", 64'(m_hit), 64'd0);
    chk("rst_lmac", 64'(m_lmac), 64'd0);
    chk("rst_resp_mac", 64'(m_resp_mac), 64'd0);
    chk("rst_resp_ip", 64'(m_resp_ip), 64'd0);
    chk("const_mac", 64'(m_mac_s), 64'(LMAC));
    chk("const_ip", 64'(m_ip_s), 64'(LIP));

    // Aging on the TICK_CYCLES=10 / AGE_LIMIT=3 instance: ticks land on edges 10,20,30,...
    frame(16'd2, 48'h0000000000AA, 32'hC0A80132, LIP);
    crc(1'b1, 1'b0);
    step();
    step_to(25);
    lookup(1'b1, 32'hC0A80132, 1'b1, 48'h0000000000AA, "age_2ticks");
    step_to(31);
    lookup(1'b1, 32'hC0A80132, 1'b0, 48'h0, "age_3ticks");
    step_to(33);
    frame(16'd2, 48'h0000000000AA, 32'hC0A80132, LIP);
    crc(1'b1, 1'b0);
    step();
    step_to(57);
    frame(16'd2, 48'h0000000000BB, 32'hC0A80132, LIP);
    crc(1'b1, 1'b0);
    step();
    lookup(1'b1, 32'hC0A80132, 1'b1, 48'h0000000000BB, "age_refresh_tick");
    step_to(75);
    lookup(1'b1, 32'hC0A80132, 1'b1, 48'h0000000000BB, "age_after_refresh");
    step_to(91);
    lookup(1'b1, 32'hC0A80132, 1'b0, 48'h0, "age_expire_again");

    do_reset();
    // Bad FCS, then both strobes together: nothing learned, no reply
    frame(16'd1, 48'h112233445566, 32'hC0A80114, LIP);
    crc(1'b0, 1'b1);
    step();
    step();
    chk("crcerr_start", 64'(m_start), 64'd0);
    lookup(1'b0, 32'hC0A80114, 1'b0, 48'h0, "crcerr_lkp");
    frame(16'd1, 48'h112233445566, 32'hC0A80114, LIP);
    crc(1'b1, 1'b1);
    step();
    step();
    chk("crcboth_start", 64'(m_start), 64'd0);
    lookup(1'b0, 32'hC0A80114, 1'b0, 48'h0, "crcboth_lkp");

    // Good request for local IP
    frame(16'd1, 48'h112233445566, 32'hC0A80114, LIP);
    crc(1'b1, 1'b0);
    chk("req_start_early", 64'(m_start), 64'd0);
    step();
    chk("req_start", 64'(m_start), 64'd1);
    chk("req_resp_ip", 64'(m_resp_ip), 64'h00000000C0A80114);
    chk("req_resp_mac", 64'(m_resp_mac), 64'h0000112233445566);
    step();
    step();
    chk("req_hold", 64'(m_start), 64'd1);
    lookup(1'b0, 32'hC0A80114, 1'b1, 48'h112233445566, "req_lkp");
    frame(16'd1, 48'h0000DEADBEEF, 32'hC0A80155, LIP);
    crc(1'b1, 1'b0);
    step();
    chk("resp_ignore_ip", 64'(m_resp_ip), 64'h00000000C0A80114);
    arp_resp_end = 1'b1;
    step();
    arp_resp_end = 1'b0;
    chk("resp_end", 64'(m_start), 64'd0);
    lookup(1'b0, 32'hC0A80155, 1'b0, 48'h0, "resp_ignore_lkp");

    do_reset();
    // Fill all 8 slots, then two more senders evict slots 0 and 1
    for (int k = 0; k < 10; k++) begin
      frame(16'd2, 48'h0000000000A0 + 48'(k), 32'h0A000001 + 32'(k), LIP);
      crc(1'b1, 1'b0);
      step();
    end
    lookup(1'b0, 32'h0A000001, 1'b0, 48'h0, "repl_s0");
    lookup(1'b0, 32'h0A000002, 1'b0, 48'h0, "repl_s1");
    lookup(1'b0, 32'h0A000003, 1'b1, 48'h0000000000A2, "repl_s2");
    lookup(1'b0, 32'h0A000008, 1'b1, 48'h0000000000A7, "repl_s7");
    lookup(1'b0, 32'h0A000009, 1'b1, 48'h0000000000A8, "repl_s8");
    lookup(1'b0, 32'h0A00000A, 1'b1, 48'h0000000000A9, "repl_s9");

    // Foreign target: new sender not learned; known sender refreshed, no reply
    frame(16'd1, 48'h0000000000B1, 32'h0B000001, 32'hC0A80163);
    crc(1'b1, 1'b0);
    step();
    step();
    chk("foreign_start", 64'(m_start), 64'd0);
    lookup(1'b0, 32'h0B000001, 1'b0, 48'h0, "foreign_new");
    frame(16'd1, 48'h0000000000C2, 32'h0A000003, 32'hC0A80163);
    crc(1'b1, 1'b0);
    step();
    step();
    chk("foreign_upd_start", 64'(m_start), 64'd0);
    lookup(1'b0, 32'h0A000003, 1'b1, 48'h0000000000C2, "foreign_upd");

    // Probe with sender 0.0.0.0 is never learned
    frame(16'd2, 48'h0000000000D0, 32'h00000000, LIP);
    crc(1'b1, 1'b0);
    step();
    lookup(1'b0, 32'h00000000, 1'b0, 48'h0, "probe");

    // Lookup coincident with UPDATE sees the old table
    frame(16'd2, 48'h0000000000E1, 32'h0C000001, LIP);
    crc(1'b1, 1'b0);
    lookup(1'b0, 32'h0C000001, 1'b0, 48'h0, "same_cyc");
    lookup(1'b0, 32'h0C000001, 1'b1, 48'h0000000000E1, "same_cyc_next");

    // Back-to-back lookups
    lkp_req = 1'b1;
    lkp_ip  = 32'h0A000004;
    step();
    chk("b2b_ack0", 64'(m_ack), 64'd1);
    chk("b2b_mac0", 64'(m_lmac), 64'h00000000000000A3);
    lkp_ip  = 32'h0A000005;
    step();
    chk("b2b_ack1", 64'(m_ack), 64'd1);
    chk("b2b_mac1", 64'(m_lmac), 64'h00000000000000A4);
    lkp_req = 1'b0;
    step();
    chk("b2b_idle", 64'(m_ack), 64'd0);

    // Reset while a reply is pending
    frame(16'd1, 48'h665544332211, 32'hC0A80120, LIP);
    crc(1'b1, 1'b0);
    step();
    chk("midrst_pre", 64'(m_start), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_start", 64'(m_start), 64'd0);
    chk("midrst_resp_ip", 64'(m_resp_ip), 64'd0);
    step();
    aresetn = 1'b1;
    step();
    lookup(1'b0, 32'h0A000004, 1'b0, 48'h0, "midrst_lkp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
